// File: rtl/issue_fifo_if.sv
// Issue-queue bus between the schedule stage / execution pipe and one issue_fifo.
// The master side pushes cells, accepts the head and may flush; the slave is the FIFO.
interface issue_fifo_if #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              flush;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic              almost_full;
    logic              empty;
    logic [CW-1:0]     count;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              overflow;

    modport master (
        output flush, wr_en, wr_data, out_ready,
        input  full, almost_full, empty, count, out_valid, out_data, overflow
    );

    modport slave (
        input  flush, wr_en, wr_data, out_ready,
        output full, almost_full, empty, count, out_valid, out_data, overflow
    );
endinterface

// File: rtl/issue_fifo.sv
// Per-pipe in-order issue queue of reservation-station cells with first-word-fall-through
// head, registered occupancy flags and a sticky overflow flag. DATA_W is $bits(res_st_cell_t).
module issue_fifo #(
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int DATA_W   = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    issue_fifo_if.slave  fifo
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          overflow_reg, overflow_next;

    logic              full_int;
    logic              empty_int;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head_word;

    assign full_int  = (count_reg == DEPTH_CNT);
    assign empty_int = (count_reg == '0);

    // push looks only at registered full, so out_ready never reaches full combinationally
    assign push = fifo.wr_en && !full_int;
    assign pop  = !empty_int && fifo.out_ready;

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;
        if (fifo.flush) begin
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            count_next    = '0;
            overflow_next = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PW'(1);
            end
            if (push && !pop) begin
                count_next = count_reg + CW'(1);
            end else if (pop && !push) begin
                count_next = count_reg - CW'(1);
            end
            if (fifo.wr_en && full_int) begin
                overflow_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

    // Storage carries no reset; stale words are hidden by the empty mask below.
    always_ff @(posedge clk) begin
        if (push && !fifo.flush) begin
            mem[wr_ptr_reg] <= fifo.wr_data;
        end
    end

    assign head_word = mem[rd_ptr_reg];

    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_head_mask
        assign fifo.out_data[gi] = head_word[gi] & ~empty_int;
    end

    assign fifo.full        = full_int;
    assign fifo.almost_full = (count_reg >= AF_CNT);
    assign fifo.empty       = empty_int;
    assign fifo.count       = count_reg;
    assign fifo.out_valid   = !empty_int;
    assign fifo.overflow    = overflow_reg;
endmodule

// File: tb/tb_issue_fifo.sv
// Bench for issue_fifo: directed scenarios followed by random traffic, all checked
// against a queue-based reference model of the issue queue.
module tb_issue_fifo;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int DW    = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    issue_fifo_if #(.DEPTH(DEPTH), .DATA_W(DW)) bus ();

    issue_fifo #(.DEPTH(DEPTH), .AF_LEVEL(AF), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fifo  (bus)
    );

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] q[$];
    bit            ovf_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ph);
        int n;
        logic [DW-1:0] head;
        n    = q.size();
        head = (n > 0) ? q[0] : '0;
        chk({ph, ".count"},       32'(bus.count),       32'(n));
        chk({ph, ".empty"},       32'(bus.empty),       32'(n == 0));
        chk({ph, ".full"},        32'(bus.full),        32'(n == DEPTH));
        chk({ph, ".almost_full"}, 32'(bus.almost_full), 32'(n >= AF));
        chk({ph, ".out_valid"},   32'(bus.out_valid),   32'(n != 0));
        chk({ph, ".out_data"},    32'(bus.out_data),    32'(head));
        chk({ph, ".overflow"},    32'(bus.overflow),    32'(ovf_m));
    endtask

    // One clock of stimulus: drive, check the current state, advance the model, clock.
    task automatic cycle(input bit w, input logic [DW-1:0] d, input bit r, input bit f,
                         input string ph);
        bit was_full;
        bus.wr_en     = w;
        bus.wr_data   = d;
        bus.out_ready = r;
        bus.flush     = f;
        #1;
        check_all(ph);
        $display("[TB] %s wr=%0d data=%0h rdy=%0d flush=%0d count=%0d head=%0h ovf=%0d",
                 ph, w, d, r, f, bus.count, bus.out_data, bus.overflow);
        if (f) begin
            q.delete();
            ovf_m = 1'b0;
        end else begin
            was_full = (q.size() == DEPTH);
            if (r && q.size() > 0) void'(q.pop_front());
            if (w) begin
                if (was_full) ovf_m = 1'b1;
                else          q.push_back(d);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.wr_en     = 1'b0;
        bus.wr_data   = '0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        ovf_m         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        // basic flow
        cycle(1, 8'hA, 0, 0, "t1.push");
        cycle(1, 8'hB, 0, 0, "t1.push");
        cycle(1, 8'hC, 0, 0, "t1.push");
        cycle(0, 8'h0, 0, 0, "t1.hold");
        chk("t1.head", 32'(bus.out_data), 32'h0A);
        repeat (3) cycle(0, 8'h0, 1, 0, "t1.pop");
        cycle(0, 8'h0, 0, 0, "t1.empty");

        // full and overflow
        for (int i = 1; i <= 4; i++) cycle(1, 8'(i), 0, 0, "t2.fill");
        cycle(1, 8'hE, 0, 0, "t2.over");
        cycle(0, 8'h0, 0, 0, "t2.ovf");
        chk("t2.ovf_set", 32'(bus.overflow), 32'd1);
        repeat (4) cycle(0, 8'h0, 1, 0, "t2.drain");
        cycle(0, 8'h0, 0, 0, "t2.after");

        // full with simultaneous push and pop
        for (int i = 0; i < 4; i++) cycle(1, 8'(8'h30 + i), 0, 0, "t3.fill");
        cycle(1, 8'h77, 1, 0, "t3.pushpop");
        cycle(0, 8'h0, 0, 0, "t3.check");
        chk("t3.count", 32'(bus.count), 32'd3);
        repeat (3) cycle(0, 8'h0, 1, 0, "t3.drain");

        // wrap-around streaming at constant occupancy 1
        cycle(1, 8'd1, 0, 0, "t4.preload");
        for (int i = 2; i <= 10; i++) cycle(1, 8'(i), 1, 0, "t4.stream");
        cycle(0, 8'h0, 1, 0, "t4.last");
        cycle(0, 8'h0, 0, 0, "t4.empty");

        // flush beats a same-cycle push and clears overflow
        cycle(1, 8'h21, 0, 0, "t5.fill");
        cycle(1, 8'h22, 0, 0, "t5.fill");
        cycle(1, 8'h23, 0, 0, "t5.fill");
        cycle(1, 8'h99, 0, 1, "t5.flush");
        chk("t5.flushed_ovf", 32'(bus.overflow), 32'd0);
        cycle(1, 8'h05, 0, 0, "t5.push5");
        cycle(0, 8'h0, 0, 0, "t5.head");
        chk("t5.head5", 32'(bus.out_data), 32'h05);

        // async reset between edges with 2 entries
        cycle(1, 8'h66, 0, 0, "t6.fill");
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6.async_valid", 32'(bus.out_valid), 32'd0);
        chk("t6.async_count", 32'(bus.count), 32'd0);
        q.delete();
        ovf_m = 1'b0;
        check_all("t6.async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1, 8'h42, 0, 0, "t6.fresh");
        cycle(0, 8'h0, 1, 0, "t6.pop");

        // random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(bit'($urandom_range(0, 1)), 8'($urandom), bit'($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 31) == 0), "rnd");
        end
        cycle(0, 8'h0, 0, 0, "final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
